atm_pin_entry_ctrl: RTL and testbench

Sequences the PIN-entry phase of an ATM session. It collects keypad digits into a packed BCD password, supports backspace, cancel and enter, and compares the entry against the stored card password from card handling. It drives the session timer (start_timer/restart_timer), counts failed attempts and decides eject, retry or retain. It sits between user_interface/card_handling and ATM_FSM, and hands over with pin_ok.

---
 rtl/atm_pin_entry_ctrl_if.sv | 33 +++
 rtl/atm_pin_entry_ctrl.sv | 177 +++++++++++++++++
 tb/tb_atm_pin_entry_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/atm_pin_entry_ctrl_if.sv
// atm_pin_entry_ctrl_if: card/keypad inputs and session outputs of the PIN-entry controller
interface atm_pin_entry_ctrl_if #(parameter int P_WIDTH = 16);
    localparam int DIGITS = P_WIDTH / 4;
    localparam int CW = $clog2(DIGITS + 1);
    logic               card_in;
    logic               pass_en;
    logic [P_WIDTH-1:0] password;
    logic [9:0]         digit_buttons;
    logic               enter_button;
    logic               cancel_button;
    logic               correct_button;
    logic               time_out;
    logic [P_WIDTH-1:0] in_password;
    logic [CW-1:0]      digit_count;
    logic               pin_ok;
    logic               wrong_password;
    logic               card_retain;
    logic               card_out;
    logic               start_timer;
    logic               restart_timer;
    modport master (
        output card_in, pass_en, password, digit_buttons, enter_button, cancel_button,
               correct_button, time_out,
        input  in_password, digit_count, pin_ok, wrong_password, card_retain, card_out,
               start_timer, restart_timer
    );
    modport slave (
        input  card_in, pass_en, password, digit_buttons, enter_button, cancel_button,
               correct_button, time_out,
        output in_password, digit_count, pin_ok, wrong_password, card_retain, card_out,
               start_timer, restart_timer
    );
endinterface

// File: rtl/atm_pin_entry_ctrl.sv
// atm_pin_entry_ctrl: PIN entry, check and retry/retain sequencing; ATM_PIN_LOCK_EN enables attempt limit and card retention
module atm_pin_entry_ctrl #(
    parameter int P_WIDTH = 16
`ifdef ATM_PIN_LOCK_EN
    , parameter int MAX_TRIES = 3
`endif
) (
    input logic clk,
    input logic rst,
    atm_pin_entry_ctrl_if.slave bus
);
    localparam int DIGITS = P_WIDTH / 4;
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [2:0] {IDLE, WAIT_PASS, ENTRY, CHECK, WRONG, OK, LOCKED, EJECT} state_t;

    state_t             state;
    logic [P_WIDTH-1:0] stored;
    logic [P_WIDTH-1:0] entry;
    logic [CW-1:0]      count;
    logic [9:0]         digit_q;
    logic               enter_q;
    logic               cancel_q;
    logic               correct_q;
    logic               pin_ok;
    logic               wrong_password;
    logic               card_out;
    logic               start_timer;
    logic               restart_timer;
    logic [9:0]         digit_rise;
    logic               digit_hit;
    logic [3:0]         digit_val;
    logic               enter_e;
    logic               cancel_e;
    logic               correct_e;
    logic               full;
    logic               empty;
`ifdef ATM_PIN_LOCK_EN
    logic [2:0]         attempts;
    logic [2:0]         attempts_nxt;
    logic               card_retain;
    assign attempts_nxt = (attempts == 3'd7) ? 3'd7 : attempts + 3'd1;
    assign bus.card_retain = card_retain;
`else
    assign bus.card_retain = 1'b0;
`endif

    assign digit_rise = bus.digit_buttons & ~digit_q;
    assign digit_hit  = (digit_rise != '0) && ((digit_rise & (digit_rise - 10'd1)) == '0);
    assign enter_e    = bus.enter_button & ~enter_q;
    assign cancel_e   = bus.cancel_button & ~cancel_q;
    assign correct_e  = bus.correct_button & ~correct_q;
    assign full       = count == CW'(DIGITS);
    assign empty      = count == '0;

    assign bus.in_password    = entry;
    assign bus.digit_count    = count;
    assign bus.pin_ok         = pin_ok;
    assign bus.wrong_password = wrong_password;
    assign bus.card_out       = card_out;
    assign bus.start_timer    = start_timer;
    assign bus.restart_timer  = restart_timer;

    // Encode the single rising keypad bit into its BCD digit value
    always_comb begin
        digit_val = '0;
        for (int i = 0; i < 10; i++)
            if (digit_rise[i]) digit_val = 4'(i);
    end

    // Session state machine with key-edge history and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            stored         <= '0;
            entry          <= '0;
            count          <= '0;
            digit_q        <= '0;
            enter_q        <= 1'b0;
            cancel_q       <= 1'b0;
            correct_q      <= 1'b0;
            pin_ok         <= 1'b0;
            wrong_password <= 1'b0;
            card_out       <= 1'b0;
            start_timer    <= 1'b0;
            restart_timer  <= 1'b0;
`ifdef ATM_PIN_LOCK_EN
            attempts       <= '0;
            card_retain    <= 1'b0;
`endif
        end else begin
            digit_q        <= bus.digit_buttons;
            enter_q        <= bus.enter_button;
            cancel_q       <= bus.cancel_button;
            correct_q      <= bus.correct_button;
            wrong_password <= 1'b0;
            restart_timer  <= 1'b0;
            if (!bus.card_in) begin
                state       <= IDLE;
                entry       <= '0;
                count       <= '0;
                pin_ok      <= 1'b0;
                card_out    <= 1'b0;
                start_timer <= 1'b0;
`ifdef ATM_PIN_LOCK_EN
                attempts    <= '0;
                card_retain <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: state <= WAIT_PASS;
                    WAIT_PASS: if (bus.pass_en) begin
                        stored        <= bus.password;
                        state         <= ENTRY;
                        start_timer   <= 1'b1;
                        restart_timer <= 1'b1;
                    end
                    ENTRY: if (bus.time_out || cancel_e) begin
                        state       <= EJECT;
                        card_out    <= 1'b1;
                        start_timer <= 1'b0;
                        entry       <= '0;
                        count       <= '0;
                    end else if (enter_e) begin
                        if (full) state <= CHECK;
                    end else if (correct_e) begin
                        if (!empty) begin
                            entry         <= entry >> 4;
                            count         <= count - CW'(1);
                            restart_timer <= 1'b1;
                        end
                    end else if (digit_hit && !full) begin
                        entry         <= {entry[P_WIDTH-5:0], digit_val};
                        count         <= count + CW'(1);
                        restart_timer <= 1'b1;
                    end
                    CHECK: if (entry == stored) begin
                        state       <= OK;
                        pin_ok      <= 1'b1;
                        start_timer <= 1'b0;
`ifdef ATM_PIN_LOCK_EN
                        attempts    <= '0;
`endif
                    end else begin
                        wrong_password <= 1'b1;
`ifdef ATM_PIN_LOCK_EN
                        attempts <= attempts_nxt;
                        if (attempts_nxt == 3'(MAX_TRIES)) begin
                            state       <= LOCKED;
                            card_retain <= 1'b1;
                            start_timer <= 1'b0;
                        end else begin
                            state <= WRONG;
                        end
`else
                        state <= WRONG;
`endif
                    end
                    WRONG: begin
                        entry         <= '0;
                        count         <= '0;
                        restart_timer <= 1'b1;
                        state         <= ENTRY;
                    end
                    OK: if (cancel_e) begin
                        state    <= EJECT;
                        pin_ok   <= 1'b0;
                        card_out <= 1'b1;
                        entry    <= '0;
                        count    <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_atm_pin_entry_ctrl.sv
// tb_atm_pin_entry_ctrl: directed vector table plus hand sequences for the PIN-entry controller
module tb_atm_pin_entry_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    atm_pin_entry_ctrl_if #(.P_WIDTH(16)) bus ();
    atm_pin_entry_ctrl #(.P_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int          ci, pe;
        logic [9:0]  dg;
        int          en, ca, co;
        logic [24:0] exp;
    } vec_t;

    vec_t tbl[$];

    // flags = {pin_ok, wrong_password, card_retain, card_out, start_timer, restart_timer}
    function automatic logic [24:0] o(input logic [15:0] ip, input int dc, input logic [5:0] f);
        return {ip, 3'(dc), f};
    endfunction

    function automatic logic [9:0] d(input int n);
        return 10'(1) << n;
    endfunction

    function automatic string fmt(input logic [24:0] v);
        return $sformatf("ip=%h dc=%0d ok=%b wr=%b ret=%b out=%b st=%b rt=%b",
                         v[24:9], v[8:6], v[5], v[4], v[3], v[2], v[1], v[0]);
    endfunction

    function automatic void add(input int ci, pe, input logic [9:0] dg, input int en, ca, co,
                                input logic [24:0] exp);
        tbl.push_back('{ci, pe, dg, en, ca, co, exp});
    endfunction

    task automatic step(input int ci, pe, input logic [15:0] pw, input logic [9:0] dg,
                        input int en, ca, co, to);
        @(negedge clk);
        bus.card_in        = 1'(ci);
        bus.pass_en        = 1'(pe);
        bus.password       = pw;
        bus.digit_buttons  = dg;
        bus.enter_button   = 1'(en);
        bus.cancel_button  = 1'(ca);
        bus.correct_button = 1'(co);
        bus.time_out       = 1'(to);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [24:0] exp);
        logic [24:0] got;
        got = {bus.in_password, bus.digit_count, bus.pin_ok, bus.wrong_password,
               bus.card_retain, bus.card_out, bus.start_timer, bus.restart_timer};
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic enter_code(input logic [15:0] v);
        for (int i = 3; i >= 0; i--) begin
            step(1, 0, 16'h0, d(int'(v[i*4 +: 4])), 0, 0, 0, 0);
            step(1, 0, 16'h0, 10'd0, 0, 0, 0, 0);
        end
        chk("code_loaded", o(v, 4, 6'b000010));
        step(1, 0, 16'h0, 10'd0, 1, 0, 0, 0);
        chk("check_cycle", o(v, 4, 6'b000010));
        step(1, 0, 16'h0, 10'd0, 0, 0, 0, 0);
    endtask

    initial begin
        // correct PIN, then cancel from OK
        add(1, 0, 10'd0, 0, 0, 0, o(16'h0000, 0, 6'b000000));
        add(1, 1, 10'd0, 0, 0, 0, o(16'h0000, 0, 6'b000011));
        add(1, 0, d(1),  0, 0, 0, o(16'h0001, 1, 6'b000011));
        add(1, 0, 10'd0, 0, 0, 0, o(16'h0001, 1, 6'b000010));
        add(1, 0, d(2),  0, 0, 0, o(16'h0012, 2, 6'b000011));
        add(1, 0, 10'd0, 0, 0, 0, o(16'h0012, 2, 6'b000010));
        add(1, 0, d(3),  0, 0, 0, o(16'h0123, 3, 6'b000011));
        add(1, 0, 10'd0, 0, 0, 0, o(16'h0123, 3, 6'b000010));
        add(1, 0, d(4),  0, 0, 0, o(16'h1234, 4, 6'b000011));
        add(1, 0, 10'd0, 0, 0, 0, o(16'h1234, 4, 6'b000010));
        add(1, 0, 10'd0, 1, 0, 0, o(16'h1234, 4, 6'b000010));
        add(1, 0, 10'd0, 1, 0, 0, o(16'h1234, 4, 6'b100000));
        add(1, 0, 10'd0, 0, 0, 0, o(16'h1234, 4, 6'b100000));
        add(1, 0, 10'd0, 0, 1, 0, o(16'h0000, 0, 6'b000100));
        add(1, 0, 10'd0, 0, 0, 0, o(16'h0000, 0, 6'b000100));
        add(0, 0, 10'd0, 0, 0, 0, o(16'h0000, 0, 6'b000000));
        // backspace, ignored keys at the count boundaries
        add(1, 0, 10'd0, 0, 0, 0, o(16'h0000, 0, 6'b000000));
        add(1, 1, 10'd0, 0, 0, 0, o(16'h0000, 0, 6'b000011));
        add(1, 0, 10'd0, 0, 0, 1, o(16'h0000, 0, 6'b000010));
        add(1, 0, 10'd0, 0, 0, 0, o(16'h0000, 0, 6'b000010));
        add(1, 0, d(1),  0, 0, 0, o(16'h0001, 1, 6'b000011));
        add(1, 0, 10'd0, 0, 0, 0, o(16'h0001, 1, 6'b000010));
        add(1, 0, d(2),  0, 0, 0, o(16'h0012, 2, 6'b000011));
        add(1, 0, 10'd0, 0, 0, 0, o(16'h0012, 2, 6'b000010));
        add(1, 0, 10'd0, 1, 0, 0, o(16'h0012, 2, 6'b000010));
        add(1, 0, 10'd0, 0, 0, 0, o(16'h0012, 2, 6'b000010));
        add(1, 0, d(9),  0, 0, 0, o(16'h0129, 3, 6'b000011));
        add(1, 0, 10'd0, 0, 0, 0, o(16'h0129, 3, 6'b000010));
        add(1, 0, 10'd0, 0, 0, 1, o(16'h0012, 2, 6'b000011));
        add(1, 0, 10'd0, 0, 0, 0, o(16'h0012, 2, 6'b000010));
        add(1, 0, d(3),  0, 0, 0, o(16'h0123, 3, 6'b000011));
        add(1, 0, 10'd0, 0, 0, 0, o(16'h0123, 3, 6'b000010));
        add(1, 0, d(4),  0, 0, 0, o(16'h1234, 4, 6'b000011));
        add(1, 0, 10'd0, 0, 0, 0, o(16'h1234, 4, 6'b000010));
        add(1, 0, d(5),  0, 0, 0, o(16'h1234, 4, 6'b000010));
        add(1, 0, 10'd0, 0, 0, 0, o(16'h1234, 4, 6'b000010));
        add(1, 0, 10'd0, 1, 0, 0, o(16'h1234, 4, 6'b000010));
        add(1, 0, 10'd0, 0, 0, 0, o(16'h1234, 4, 6'b100000));
        add(0, 0, 10'd0, 0, 0, 0, o(16'h0000, 0, 6'b000000));

        rst = 1'b0;
        bus.card_in = 1'b0; bus.pass_en = 1'b0; bus.password = '0; bus.digit_buttons = '0;
        bus.enter_button = 1'b0; bus.cancel_button = 1'b0; bus.correct_button = 1'b0;
        bus.time_out = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", '0);
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].ci, tbl[i].pe, 16'h1234, tbl[i].dg, tbl[i].en, tbl[i].ca, tbl[i].co, 0);
            chk($sformatf("vec%0d", i), tbl[i].exp);
        end

        // repeated wrong entries
        step(1, 0, 16'h0, 10'd0, 0, 0, 0, 0);
        chk("wrong_wait", '0);
        step(1, 1, 16'h1234, 10'd0, 0, 0, 0, 0);
        chk("wrong_start", o(16'h0000, 0, 6'b000011));
        for (int k = 0; k < 3; k++) begin
            enter_code(16'h1111);
`ifdef ATM_PIN_LOCK_EN
            if (k == 2) begin
                chk("lock_pulse", o(16'h1111, 4, 6'b011000));
                step(1, 0, 16'h0, 10'd0, 0, 0, 0, 0);
                chk("locked_hold", o(16'h1111, 4, 6'b001000));
            end else
`endif
            begin
                chk("wrong_pulse", o(16'h1111, 4, 6'b010010));
                step(1, 0, 16'h0, 10'd0, 0, 0, 0, 0);
                chk("wrong_cleared", o(16'h0000, 0, 6'b000011));
            end
        end
`ifndef ATM_PIN_LOCK_EN
        enter_code(16'h1234);
        chk("fourth_ok", o(16'h1234, 4, 6'b100000));
`endif
        step(0, 0, 16'h0, 10'd0, 0, 0, 0, 0);
        chk("wrong_seq_idle", '0);

        // time_out wins over a simultaneous enter
        step(1, 0, 16'h0, 10'd0, 0, 0, 0, 0);
        step(1, 1, 16'h1234, 10'd0, 0, 0, 0, 0);
        chk("to_start", o(16'h0000, 0, 6'b000011));
        step(1, 0, 16'h0, d(7), 0, 0, 0, 0);
        step(1, 0, 16'h0, 10'd0, 0, 0, 0, 0);
        step(1, 0, 16'h0, d(8), 0, 0, 0, 0);
        step(1, 0, 16'h0, 10'd0, 0, 0, 0, 0);
        chk("two_digits", o(16'h0078, 2, 6'b000010));
        step(1, 0, 16'h0, 10'd0, 1, 0, 0, 1);
        chk("timeout_eject", o(16'h0000, 0, 6'b000100));
        step(1, 0, 16'h0, 10'd0, 0, 0, 0, 0);
        chk("eject_hold", o(16'h0000, 0, 6'b000100));
        step(0, 0, 16'h0, 10'd0, 0, 0, 0, 0);
        chk("eject_idle", '0);

        // held digit acts once, dual rise ignored, async reset mid-entry
        step(1, 0, 16'h0, 10'd0, 0, 0, 0, 0);
        step(1, 1, 16'h1234, 10'd0, 0, 0, 0, 0);
        step(1, 0, 16'h0, d(5), 0, 0, 0, 0);
        chk("held_first", o(16'h0005, 1, 6'b000011));
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 16'h0, d(5), 0, 0, 0, 0);
            chk("held_repeat", o(16'h0005, 1, 6'b000010));
        end
        step(1, 0, 16'h0, 10'd0, 0, 0, 0, 0);
        step(1, 0, 16'h0, d(5) | d(6), 0, 0, 0, 0);
        chk("dual_ignored", o(16'h0005, 1, 6'b000010));
        #2 rst = 1'b0;
        #1 chk("async_reset", '0);
        @(negedge clk) rst = 1'b1;
        step(0, 0, 16'h0, 10'd0, 0, 0, 0, 0);
        chk("post_reset", '0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
